// File: rtl/cla_serial_subtractor.sv
// cla_serial_subtractor: multi-cycle unsigned subtractor computing (a - b) mod 2^WIDTH,
// three bits per clock through a single 3-bit carry look-ahead slice. The subtraction
// is done as a + ~b + 1, so the carry is seeded to 1 and borrow is the inverted final carry.
module cla_serial_subtractor #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int N  = WIDTH / 3;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic             load;      // capture operands this edge
    logic             step;      // process slice k this edge
    logic             last;      // slice k is the final slice

    logic [WIDTH-1:0] a_r;       // latched minuend
    logic [WIDTH-1:0] nb_r;      // latched, inverted subtrahend
    logic [WIDTH-1:0] res_r;     // partial result, never exposed on diff
    logic [WIDTH-1:0] res_nx;    // partial result with slice k filled in
    logic             c;         // carry into slice k
    logic [KW-1:0]    k;         // slice index

    logic [2:0]       x, y, g, p, s;
    logic             c1, c2, c3;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (k == K_LAST) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One 3-bit look-ahead slice over a_r and ~b at slice k, plus the merged result.
    always_comb begin
        x  = a_r[3*k +: 3];
        y  = nb_r[3*k +: 3];
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        s  = p ^ {c2, c1, c};
        res_nx             = res_r;
        res_nx[3*k +: 3]   = s;
    end

    // Operand and scratch registers.
    always_ff @(posedge clk) begin
        // NOTE: these registers carry no reset: they are always loaded on start before
        // anything reads them, and nothing outside sees them.
        if (load) begin
            a_r  <= a;
            nb_r <= ~b;
        end
        if (step) begin
            res_r <= res_nx;
        end
    end

    // Carry/index sequencing and the published result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // updates from the values present before the edge.
        if (rst) begin
            c      <= 1'b0;
            k      <= '0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                c <= 1'b1;
                k <= '0;
            end
            if (step) begin
                c <= c3;
                k <= k + KW'(1);
            end
            if (last) begin
                diff   <= res_nx;
                borrow <= ~c3;
                zero   <= (res_nx == '0);
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Self-checking bench for cla_serial_subtractor (WIDTH=12): directed vectors feed a
// scoreboard queue; a monitor pops and compares whenever done is seen.
module tb_cla_serial_subtractor;

    localparam int WIDTH = 12;
    localparam int N     = WIDTH / 3;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, borrow, zero;
    logic [WIDTH-1:0] diff;

    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   issued = 0;
    exp_t sb[$];
    logic done_prev = 1'b0;

    cla_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            check("done_not_consecutive", {31'd0, done_prev}, 32'd0);
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", {20'd0, diff}, {20'd0, e.diff});
                check("borrow", {31'd0, borrow}, {31'd0, e.borrow});
                check("zero", {31'd0, zero}, {31'd0, e.zero});
            end
        end
        done_prev = (done === 1'b1);
    end

    // Issue one request at the current negedge and wait for its done.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
        int lat;
        int busy_cycles;
        start = 1'b1;
        a     = av;
        b     = bv;
        sb.push_back('{diff: ed, borrow: eb, zero: ez});
        issued++;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;     // operand changes after sampling must not matter
        b     = ~bv;
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, N);
        check("busy_cycles", busy_cycles, N);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset for two cycles, then idle with start low: all outputs stay 0.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            check("reset_idle_outputs", {16'd0, busy, done, borrow, zero, diff},
                  32'd0);
        end

        // Basic subtraction.
        run_op(12'h123, 12'h045, 12'h0DE, 1'b0, 1'b0);
        idle_cycles(2);

        // Underflow, then back-to-back start in the done cycle with equal operands.
        run_op(12'h005, 12'h009, 12'hFFC, 1'b1, 1'b0);
        run_op(12'hABC, 12'hABC, 12'h000, 1'b0, 1'b1);
        idle_cycles(2);

        // Full carry chain across all slices.
        run_op(12'h800, 12'h001, 12'h7FF, 1'b0, 1'b0);
        idle_cycles(2);

        // Start while busy is ignored.
        start = 1'b1;
        a     = 12'h100;
        b     = 12'h001;
        sb.push_back('{diff: 12'h0FF, borrow: 1'b0, zero: 1'b0});
        issued++;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 12'hFFF;
        b     = 12'hFFF;
        @(negedge clk);
        start = 1'b0;
        idle_cycles(10);
        check("ignored_start_done_count", done_seen, issued);
        check("result_holds", {20'd0, diff}, 32'h0FF);

        // Reset mid-operation aborts without a done.
        start = 1'b1;
        a     = 12'h321;
        b     = 12'h123;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", {20'd0, diff}, 32'd0);
        idle_cycles(10);
        check("abort_no_done", done_seen, issued);

        // Fresh operation after the abort.
        run_op(12'h321, 12'h123, 12'h1FE, 1'b0, 1'b0);
        idle_cycles(3);

        check("scoreboard_empty", sb.size(), 0);
        check("total_done_count", done_seen, issued);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
